mult_arbiter: RTL and testbench

//  Shares one parity-checked 16x16 multiplier (req/ack/result_rdy protocol) between N_REQ requesters.

---
 rtl/mult_arbiter.sv | 217 +++++++++++++++++++++
 tb/tb_mult_arbiter.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_arbiter.sv
// Round-robin arbiter sharing one parity-checked multiplier between N_REQ requesters.
// Optional watchdog: define MULT_ARB_TIMEOUT_EN to abort a stalled transaction after TIMEOUT_CYC cycles.
module mult_arbiter #(
  parameter int N_REQ       = 2,
  parameter int DATA_W      = 16,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_REQ-1:0]          req_valid,
  output logic [N_REQ-1:0]          req_ready,
  input  logic [N_REQ*DATA_W-1:0]   req_arg_a,
  input  logic [N_REQ-1:0]          req_arg_a_parity,
  input  logic [N_REQ*DATA_W-1:0]   req_arg_b,
  input  logic [N_REQ-1:0]          req_arg_b_parity,
  output logic [N_REQ-1:0]          rsp_valid,
  output logic [2*DATA_W-1:0]       rsp_result,
  output logic                      rsp_result_parity,
  output logic                      rsp_parity_error,
  output logic                      rsp_timeout,
  output logic                      mult_req,
  output logic [DATA_W-1:0]         mult_arg_a,
  output logic [DATA_W-1:0]         mult_arg_b,
  output logic                      mult_arg_a_parity,
  output logic                      mult_arg_b_parity,
  input  logic                      mult_ack,
  input  logic [2*DATA_W-1:0]       mult_result,
  input  logic                      mult_result_parity,
  input  logic                      mult_arg_parity_error,
  input  logic                      mult_result_rdy,
  output logic [1:0]                dbg_state
);

  localparam int PW = $clog2(N_REQ);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ISSUE    = 2'd1,
    ST_WAIT_RDY = 2'd2,
    ST_RESP     = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [PW-1:0]       ptr_q, ptr_d;
  logic [N_REQ-1:0]    req_ready_q, req_ready_d;
  logic [N_REQ-1:0]    rsp_valid_q, rsp_valid_d;
  logic                mult_req_q, mult_req_d;
  logic [DATA_W-1:0]   arg_a_q, arg_a_d;
  logic [DATA_W-1:0]   arg_b_q, arg_b_d;
  logic                arg_a_par_q, arg_a_par_d;
  logic                arg_b_par_q, arg_b_par_d;
  logic [2*DATA_W-1:0] result_q, result_d;
  logic                result_par_q, result_par_d;
  logic                par_err_q, par_err_d;
  logic                timeout_q, timeout_d;

  logic                grant_found;
  logic [PW-1:0]       grant_idx;
  logic [PW-1:0]       cand;
  logic                done;
  logic                timeout_hit;

  // Search starts one past the last winner so every requester is served within N_REQ-1 grants.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand = PW'((int'(ptr_q) + k) % N_REQ);
      if (!grant_found && req_valid[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

`ifdef MULT_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYC) + 1;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (state_q == ST_IDLE) begin
      cnt_d = '0;
    end else if (state_q == ST_ISSUE || state_q == ST_WAIT_RDY) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign timeout_hit = (state_q == ST_ISSUE || state_q == ST_WAIT_RDY) &&
                       (cnt_q == CW'(TIMEOUT_CYC - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  // A real completion seen in the same cycle as the watchdog limit wins over the timeout.
  assign done = (state_q == ST_ISSUE && mult_ack && mult_result_rdy) ||
                (state_q == ST_WAIT_RDY && mult_result_rdy);

  // Requester side: req_valid is a level; req_ready[i] is a one-cycle pulse meaning the operands of
  // requester i were latched on that edge. Multiplier side: mult_req holds until the cycle mult_ack
  // is sampled; mult_result_rdy is a one-cycle pulse qualifying result, parity and error together.
  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    req_ready_d  = '0;
    rsp_valid_d  = '0;
    mult_req_d   = mult_req_q;
    arg_a_d      = arg_a_q;
    arg_b_d      = arg_b_q;
    arg_a_par_d  = arg_a_par_q;
    arg_b_par_d  = arg_b_par_q;
    result_d     = result_q;
    result_par_d = result_par_q;
    par_err_d    = par_err_q;
    timeout_d    = timeout_q;

    case (state_q)
      ST_IDLE: begin
        if (grant_found) begin
          ptr_d       = grant_idx;
          req_ready_d = N_REQ'(1) << grant_idx;
          arg_a_d     = req_arg_a[int'(grant_idx)*DATA_W +: DATA_W];
          arg_b_d     = req_arg_b[int'(grant_idx)*DATA_W +: DATA_W];
          arg_a_par_d = req_arg_a_parity[grant_idx];
          arg_b_par_d = req_arg_b_parity[grant_idx];
          mult_req_d  = 1'b1;
          state_d     = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (mult_ack) begin
          mult_req_d = 1'b0;
          state_d    = ST_WAIT_RDY;
        end
      end
      ST_WAIT_RDY: begin
        state_d = ST_WAIT_RDY;
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (done) begin
      result_d     = mult_result;
      result_par_d = mult_result_parity;
      par_err_d    = mult_arg_parity_error;
      timeout_d    = 1'b0;
      rsp_valid_d  = N_REQ'(1) << ptr_q;
      mult_req_d   = 1'b0;
      state_d      = ST_RESP;
    end else if (timeout_hit) begin
      result_d     = '0;
      result_par_d = 1'b0;
      par_err_d    = 1'b0;
      timeout_d    = 1'b1;
      rsp_valid_d  = N_REQ'(1) << ptr_q;
      mult_req_d   = 1'b0;
      state_d      = ST_RESP;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      ptr_q        <= PW'(N_REQ - 1);
      req_ready_q  <= '0;
      rsp_valid_q  <= '0;
      mult_req_q   <= 1'b0;
      arg_a_q      <= '0;
      arg_b_q      <= '0;
      arg_a_par_q  <= 1'b0;
      arg_b_par_q  <= 1'b0;
      result_q     <= '0;
      result_par_q <= 1'b0;
      par_err_q    <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      req_ready_q  <= req_ready_d;
      rsp_valid_q  <= rsp_valid_d;
      mult_req_q   <= mult_req_d;
      arg_a_q      <= arg_a_d;
      arg_b_q      <= arg_b_d;
      arg_a_par_q  <= arg_a_par_d;
      arg_b_par_q  <= arg_b_par_d;
      result_q     <= result_d;
      result_par_q <= result_par_d;
      par_err_q    <= par_err_d;
      timeout_q    <= timeout_d;
    end
  end

  assign req_ready         = req_ready_q;
  assign rsp_valid         = rsp_valid_q;
  assign rsp_result        = result_q;
  assign rsp_result_parity = result_par_q;
  assign rsp_parity_error  = par_err_q;
  assign rsp_timeout       = timeout_q;
  assign mult_req          = mult_req_q;
  assign mult_arg_a        = arg_a_q;
  assign mult_arg_b        = arg_b_q;
  assign mult_arg_a_parity = arg_a_par_q;
  assign mult_arg_b_parity = arg_b_par_q;
  assign dbg_state         = state_q;

endmodule

// File: tb/tb_mult_arbiter.sv
// Directed + randomized bench for mult_arbiter with a behavioural multiplier and round-robin model.
// Expects the long-wait behaviour by default and the watchdog behaviour when MULT_ARB_TIMEOUT_EN is set.
module tb_mult_arbiter;
  localparam int N  = 3;
  localparam int W  = 16;
  localparam int TO = 8;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [N*W-1:0] req_arg_a;
  logic [N-1:0]   req_arg_a_parity;
  logic [N*W-1:0] req_arg_b;
  logic [N-1:0]   req_arg_b_parity;
  logic [N-1:0]   rsp_valid;
  logic [2*W-1:0] rsp_result;
  logic           rsp_result_parity;
  logic           rsp_parity_error;
  logic           rsp_timeout;
  logic           mult_req;
  logic [W-1:0]   mult_arg_a;
  logic [W-1:0]   mult_arg_b;
  logic           mult_arg_a_parity;
  logic           mult_arg_b_parity;
  logic           mult_ack;
  logic [2*W-1:0] mult_result;
  logic           mult_result_parity;
  logic           mult_arg_parity_error;
  logic           mult_result_rdy;
  logic [1:0]     dbg_state;

  logic [W-1:0] op_a [N];
  logic [W-1:0] op_b [N];

  for (genvar i = 0; i < N; i++) begin : g_pack
    assign req_arg_a[i*W +: W] = op_a[i];
    assign req_arg_b[i*W +: W] = op_b[i];
  end

  mult_arbiter #(.N_REQ(N), .DATA_W(W), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_arg_a(req_arg_a), .req_arg_a_parity(req_arg_a_parity),
    .req_arg_b(req_arg_b), .req_arg_b_parity(req_arg_b_parity),
    .rsp_valid(rsp_valid), .rsp_result(rsp_result),
    .rsp_result_parity(rsp_result_parity), .rsp_parity_error(rsp_parity_error),
    .rsp_timeout(rsp_timeout),
    .mult_req(mult_req), .mult_arg_a(mult_arg_a), .mult_arg_b(mult_arg_b),
    .mult_arg_a_parity(mult_arg_a_parity), .mult_arg_b_parity(mult_arg_b_parity),
    .mult_ack(mult_ack), .mult_result(mult_result),
    .mult_result_parity(mult_result_parity), .mult_arg_parity_error(mult_arg_parity_error),
    .mult_result_rdy(mult_result_rdy),
    .dbg_state(dbg_state)
  );

  int n_checks  = 0;
  int n_fail    = 0;
  int model_ptr = N - 1;
  int g;
  int hi_cycles;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference round-robin: the winner is the first requesting id after the previous winner, circularly.
  function automatic int model_grant(input logic [N-1:0] v);
    for (int k = 1; k <= N; k++) begin
      if (v[(model_ptr + k) % N]) begin
        model_ptr = (model_ptr + k) % N;
        return model_ptr;
      end
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] one_hot(input int idx);
    logic [N-1:0] v;
    v = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  task automatic set_op(input int i, input logic [W-1:0] a, input logic [W-1:0] b,
                        input bit bad_a, input bit bad_b);
    op_a[i] = a;
    op_b[i] = b;
    req_arg_a_parity[i] = (^a) ^ bad_a;
    req_arg_b_parity[i] = (^b) ^ bad_b;
  endtask

  task automatic junk_result();
    mult_result           = 2*W'({$urandom, $urandom});
    mult_result_parity    = 1'($urandom);
    mult_arg_parity_error = 1'($urandom);
  endtask

  // Driver: one arbitrated transaction with a behavioural multiplier answering after da/dr cycles.
  task automatic run_op(input logic [N-1:0] vmask, input int da, input int dr,
                        input bit same, input bit scramble, input bit keep);
    int gi;
    logic [W-1:0] ea, eb;
    logic epa, epb, perr;
    logic [2*W-1:0] prod;
    req_valid = vmask;
    gi   = model_grant(vmask);
    ea   = op_a[gi];
    eb   = op_b[gi];
    epa  = req_arg_a_parity[gi];
    epb  = req_arg_b_parity[gi];
    prod = {{W{1'b0}}, ea} * {{W{1'b0}}, eb};
    perr = ((^ea) != epa) || ((^eb) != epb);
    @(negedge clk);
    check("req_ready", req_ready, one_hot(gi));
    check("mult_req_rise", mult_req, 1);
    check("mult_arg_a", mult_arg_a, ea);
    check("mult_arg_b", mult_arg_b, eb);
    check("mult_arg_a_parity", mult_arg_a_parity, epa);
    check("mult_arg_b_parity", mult_arg_b_parity, epb);
    if (!keep) req_valid = '0;
    if (scramble) begin
      req_valid = N'($urandom);
      for (int i = 0; i < N; i++) set_op(i, W'($urandom), W'($urandom), 1'($urandom), 1'($urandom));
    end
    repeat (da) begin
      @(negedge clk);
      check("mult_req_hold", mult_req, 1);
      check("mult_arg_a_hold", mult_arg_a, ea);
      check("mult_arg_b_hold", mult_arg_b, eb);
      check("req_ready_pulse", req_ready, 0);
    end
    mult_ack = 1'b1;
    if (same) begin
      mult_result_rdy       = 1'b1;
      mult_result           = prod;
      mult_result_parity    = ^prod;
      mult_arg_parity_error = perr;
    end
    @(negedge clk);
    mult_ack        = 1'b0;
    mult_result_rdy = 1'b0;
    junk_result();
    check("mult_req_drop", mult_req, 0);
    if (!same) begin
      repeat (dr) begin
        check("rsp_early", rsp_valid, 0);
        @(negedge clk);
      end
      check("rsp_before_rdy", rsp_valid, 0);
      mult_result_rdy       = 1'b1;
      mult_result           = prod;
      mult_result_parity    = ^prod;
      mult_arg_parity_error = perr;
      @(negedge clk);
      mult_result_rdy = 1'b0;
      junk_result();
    end
    check("rsp_valid", rsp_valid, one_hot(gi));
    check("rsp_result", rsp_result, prod);
    check("rsp_result_parity", rsp_result_parity, ^prod);
    check("rsp_parity_error", rsp_parity_error, perr);
    check("rsp_timeout_clear", rsp_timeout, 0);
    mult_ack        = 1'b1;
    mult_result_rdy = 1'b1;
    @(negedge clk);
    mult_ack        = 1'b0;
    mult_result_rdy = 1'b0;
    check("rsp_valid_pulse", rsp_valid, 0);
    check("rsp_result_hold", rsp_result, prod);
    check("mult_req_idle", mult_req, 0);
    req_valid = keep ? vmask : '0;
  endtask

  initial begin
    req_valid        = '0;
    req_arg_a_parity = '0;
    req_arg_b_parity = '0;
    mult_ack         = 1'b0;
    mult_result_rdy  = 1'b0;
    for (int i = 0; i < N; i++) set_op(i, '0, '0, 1'b0, 1'b0);
    junk_result();

    // reset for 3 cycles, outputs must be cleared
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_req_ready", req_ready, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_mult_req", mult_req, 0);
    check("rst_rsp_result", rsp_result, 0);
    rst = 1'b0;
    model_ptr = N - 1;
    @(negedge clk);
    check("idle_mult_req", mult_req, 0);
    check("idle_timeout", rsp_timeout, 0);

    // 3 * 5 with good parity goes to requester 0
    set_op(0, 16'h0003, 16'h0005, 1'b0, 1'b0);
    run_op(3'b001, 1, 1, 1'b0, 1'b0, 1'b0);
    check("t1_product", rsp_result, 32'h0000_000F);

    // two requesters held valid across 4 ops alternate
    set_op(0, 16'h1111, 16'h0002, 1'b0, 1'b0);
    set_op(1, 16'h0000, 16'hFFFF, 1'b0, 1'b0);
    for (int t = 0; t < 4; t++) run_op(3'b011, t % 2, 1, 1'b0, 1'b0, 1'b1);
    req_valid = '0;

    // all three held: every requester gets a turn
    for (int t = 0; t < 6; t++) run_op(3'b111, 0, 0, 1'b0, 1'b0, 1'b1);
    req_valid = '0;

    // max operands, A parity deliberately wrong, passed through unchanged
    set_op(1, 16'hFFFF, 16'hFFFF, 1'b1, 1'b0);
    run_op(3'b010, 0, 2, 1'b0, 1'b0, 1'b0);
    check("t3_product", rsp_result, 32'hFFFE_0001);

    // ack and result in the same cycle skip the wait state
    set_op(2, 16'h0100, 16'h0100, 1'b0, 1'b0);
    run_op(3'b100, 2, 0, 1'b1, 1'b0, 1'b0);

    // randomized traffic with request/operand churn while busy
    for (int t = 0; t < 24; t++) begin
      for (int i = 0; i < N; i++)
        set_op(i, W'($urandom), W'($urandom), $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0);
      run_op(N'($urandom_range(1, (1 << N) - 1)), $urandom_range(0, 2), $urandom_range(0, 2),
             1'($urandom_range(0, 1)), 1'b1, 1'b0);
    end

    // reset while waiting for the result aborts without a response
    set_op(2, 16'h1234, 16'h0002, 1'b0, 1'b0);
    req_valid = 3'b100;
    g = model_grant(3'b100);
    @(negedge clk);
    check("t5_grant", req_ready, one_hot(g));
    req_valid = '0;
    mult_ack  = 1'b1;
    @(negedge clk);
    mult_ack = 1'b0;
    check("t5_wait_req", mult_req, 0);
    check("t5_wait_rsp", rsp_valid, 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_ptr = N - 1;
    mult_result_rdy       = 1'b1;
    mult_result           = 32'h0000_2468;
    mult_result_parity    = 1'b1;
    mult_arg_parity_error = 1'b1;
    check("t5_rst_req_ready", req_ready, 0);
    check("t5_rst_mult_req", mult_req, 0);
    check("t5_rst_arg_a", mult_arg_a, 0);
    check("t5_rst_arg_b", mult_arg_b, 0);
    check("t5_rst_rsp_result", rsp_result, 0);
    @(negedge clk);
    mult_result_rdy = 1'b0;
    check("t5_no_rsp", rsp_valid, 0);
    check("t5_rsp_result_idle", rsp_result, 0);
    check("t5_parity_err_idle", rsp_parity_error, 0);
    for (int i = 0; i < N; i++) set_op(i, W'(i + 7), W'(i + 9), 1'b0, 1'b0);
    run_op(3'b111, 0, 0, 1'b0, 1'b0, 1'b0);
    check("t5_next_grant_0", model_ptr, 0);

    // stalled multiplier: never acknowledges
`ifdef MULT_ARB_TIMEOUT_EN
    set_op(1, 16'h00AA, 16'h0055, 1'b0, 1'b0);
    req_valid = 3'b010;
    g = model_grant(3'b010);
    @(negedge clk);
    req_valid = '0;
    check("t6_mult_req_rise", mult_req, 1);
    hi_cycles = 1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!mult_req) break;
      hi_cycles++;
    end
    check("t6_req_high_cycles", hi_cycles, TO);
    check("t6_rsp_valid", rsp_valid, one_hot(g));
    check("t6_rsp_timeout", rsp_timeout, 1);
    check("t6_rsp_result", rsp_result, 0);
    check("t6_rsp_parity", rsp_result_parity, 0);
    check("t6_rsp_err", rsp_parity_error, 0);
    mult_ack        = 1'b1;
    mult_result_rdy = 1'b1;
    @(negedge clk);
    mult_ack        = 1'b0;
    mult_result_rdy = 1'b0;
    check("t6_late_ignored", rsp_valid, 0);
    check("t6_late_req", mult_req, 0);
    check("t6_timeout_hold", rsp_timeout, 1);
`else
    set_op(1, 16'h00AA, 16'h0055, 1'b0, 1'b0);
    hi_cycles = 100;
    run_op(3'b010, hi_cycles, 0, 1'b1, 1'b0, 1'b0);
    check("t6_no_timeout", rsp_timeout, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
